// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 comfort monitor slice.
// Level codes, FSM states and sensor range limits.
package dht11_pkg;

    localparam logic [1:0] LVL_LOW    = 2'b00;
    localparam logic [1:0] LVL_NORMAL = 2'b01;
    localparam logic [1:0] LVL_HIGH   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_ACCUM,
        ST_CLASSIFY
    } state_t;

    localparam int DHT_TEMP_MAX = 50;
    localparam int DHT_HUM_MAX  = 95;

endpackage

// File: rtl/dht11_hyst_classifier.sv
// Three-level classifier with a hysteresis band.
// Level is updated only when en is high.
module dht11_hyst_classifier
    import dht11_pkg::*;
#(
    parameter int LOW  = 18,
    parameter int HIGH = 28,
    parameter int HYST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       first,
    input  logic [7:0] avg,
    output logic [1:0] level
);

    localparam logic [8:0] LO    = 9'(LOW);
    localparam logic [8:0] HI    = 9'(HIGH);
    localparam logic [8:0] LO_UP = 9'(LOW + HYST);
    localparam logic [8:0] HI_DN = 9'(HIGH - HYST);

    logic [8:0] a;
    logic       below;
    logic       above;
    logic       lo_exit;
    logic       hi_exit;

    assign a       = {1'b0, avg};
    assign below   = a < LO;
    assign above   = a > HI;
    assign lo_exit = a >= LO_UP;
    assign hi_exit = a <= HI_DN;

    // Level register: direct on first sample, banded afterwards
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= LVL_NORMAL;
        end else if (en) begin
            if (first) begin
                level <= below ? LVL_LOW
                       : above ? LVL_HIGH
                       : LVL_NORMAL;
            end else begin
                unique case (level)
                    LVL_LOW: begin
                        if (above)
                            level <= LVL_HIGH;
                        else if (lo_exit)
                            level <= LVL_NORMAL;
                    end
                    LVL_HIGH: begin
                        if (below)
                            level <= LVL_LOW;
                        else if (hi_exit)
                            level <= LVL_NORMAL;
                    end
                    default: begin
                        level <= below ? LVL_LOW
                               : above ? LVL_HIGH
                               : LVL_NORMAL;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/dht11_comfort_monitor.sv
// Range-checks DHT11 readings, averages them over a ring
// buffer, classifies with hysteresis and flags stale data.
module dht11_comfort_monitor
    import dht11_pkg::*;
#(
    parameter int AVG_LOG2     = 2,
    parameter int TEMP_LOW     = 18,
    parameter int TEMP_HIGH    = 28,
    parameter int HUM_LOW      = 30,
    parameter int HUM_HIGH     = 70,
    parameter int HYST         = 1,
    parameter int TEMP_MAX     = DHT_TEMP_MAX,
    parameter int HUM_MAX      = DHT_HUM_MAX,
    parameter int STALE_CYCLES = 375000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] humidity,
    input  logic [15:0] temperature,
    input  logic        valid,
    output logic [7:0]  hum_avg,
    output logic [7:0]  temp_avg,
    output logic [1:0]  hum_level,
    output logic [1:0]  temp_level,
    output logic        update,
    output logic        stale,
    output logic [7:0]  reject_cnt
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = 8 + AVG_LOG2;
    localparam int TW    = $clog2(STALE_CYCLES + 1);
    localparam logic [TW-1:0] STALE_MAX = TW'(STALE_CYCLES);

    state_t              state;
    logic                valid_q;
    logic                vedge;
    logic                primed;
    logic                in_range;
    logic                acc_en;
    logic [7:0]          t_s;
    logic [7:0]          h_s;
    logic [SW-1:0]       t_sum;
    logic [SW-1:0]       h_sum;
    logic [SW-1:0]       t_nsum;
    logic [SW-1:0]       h_nsum;
    logic [7:0]          t_navg;
    logic [7:0]          h_navg;
    logic [7:0]          t_ring [DEPTH];
    logic [7:0]          h_ring [DEPTH];
    logic [AVG_LOG2-1:0] ptr;
    logic [TW-1:0]       timer;
    logic                unused_dec;

    assign unused_dec = ^{humidity[7:0], temperature[7:0]};
    assign vedge      = valid & ~valid_q;
    assign acc_en     = state == ST_ACCUM;
    assign in_range   = (t_s <= 8'(TEMP_MAX))
                      && (h_s <= 8'(HUM_MAX));
    assign stale      = (timer == STALE_MAX) | ~primed;

    // Running sums after the sample currently held
    always_comb begin
        t_nsum = SW'(t_s) << AVG_LOG2;
        h_nsum = SW'(h_s) << AVG_LOG2;
        if (primed) begin
            t_nsum = t_sum - SW'(t_ring[ptr]) + SW'(t_s);
            h_nsum = h_sum - SW'(h_ring[ptr]) + SW'(h_s);
        end
    end

    assign t_navg = t_nsum[SW-1:AVG_LOG2];
    assign h_navg = h_nsum[SW-1:AVG_LOG2];

    // Sample FSM with buffer, sums and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            valid_q    <= 1'b0;
            primed     <= 1'b0;
            t_s        <= '0;
            h_s        <= '0;
            t_sum      <= '0;
            h_sum      <= '0;
            ptr        <= '0;
            temp_avg   <= '0;
            hum_avg    <= '0;
            update     <= 1'b0;
            reject_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                t_ring[i] <= '0;
                h_ring[i] <= '0;
            end
        end else begin
            valid_q <= valid;
            update  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (vedge) begin
                        t_s   <= temperature[15:8];
                        h_s   <= humidity[15:8];
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (!in_range) begin
                        if (reject_cnt != 8'hff)
                            reject_cnt <= reject_cnt + 8'd1;
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    t_sum <= t_nsum;
                    h_sum <= h_nsum;
                    if (!primed) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            t_ring[i] <= t_s;
                            h_ring[i] <= h_s;
                        end
                    end else begin
                        t_ring[ptr] <= t_s;
                        h_ring[ptr] <= h_s;
                        ptr         <= ptr + 1'b1;
                    end
                    primed   <= 1'b1;
                    temp_avg <= t_navg;
                    hum_avg  <= h_navg;
                    update   <= 1'b1;
                    state    <= ST_CLASSIFY;
                end
                ST_CLASSIFY: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stale timer: cleared by an accepted sample, saturates
    always_ff @(posedge clk) begin
        if (rst)
            timer <= '0;
        else if (acc_en)
            timer <= '0;
        else if (timer != STALE_MAX)
            timer <= timer + 1'b1;
    end

    dht11_hyst_classifier #(
        .LOW  (TEMP_LOW),
        .HIGH (TEMP_HIGH),
        .HYST (HYST)
    ) u_temp_cls (
        .clk   (clk),
        .rst   (rst),
        .en    (acc_en),
        .first (~primed),
        .avg   (t_navg),
        .level (temp_level)
    );

    dht11_hyst_classifier #(
        .LOW  (HUM_LOW),
        .HIGH (HUM_HIGH),
        .HYST (HYST)
    ) u_hum_cls (
        .clk   (clk),
        .rst   (rst),
        .en    (acc_en),
        .first (~primed),
        .avg   (h_navg),
        .level (hum_level)
    );

endmodule

// File: tb/tb_dht11_comfort_monitor.sv
// Randomized self-checking bench for dht11_comfort_monitor.
// Reference model: sliding window of samples plus level rules.
module tb_dht11_comfort_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] humidity = '0;
    logic [15:0] temperature = '0;
    logic        valid = 1'b0;
    logic [7:0]  hum_avg;
    logic [7:0]  temp_avg;
    logic [1:0]  hum_level;
    logic [1:0]  temp_level;
    logic        update;
    logic        stale;
    logic [7:0]  reject_cnt;

    int checks = 0;
    int failures = 0;

    int       win [$];
    int       hwin [$];
    bit       m_primed;
    logic [1:0] m_tl;
    logic [1:0] m_hl;
    int       m_tavg;
    int       m_havg;
    int       m_rej;

    always #5 clk = ~clk;

    dht11_comfort_monitor #(
        .STALE_CYCLES (100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .humidity    (humidity),
        .temperature (temperature),
        .valid       (valid),
        .hum_avg     (hum_avg),
        .temp_avg    (temp_avg),
        .hum_level   (hum_level),
        .temp_level  (temp_level),
        .update      (update),
        .stale       (stale),
        .reject_cnt  (reject_cnt)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d",
                     tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] nxt_lvl(
        logic [1:0] cur, bit first,
        int a, int lo, int hi);
        if (first || cur == 2'b01)
            return a < lo ? 2'b00 : (a > hi ? 2'b10 : 2'b01);
        if (cur == 2'b00)
            return a > hi ? 2'b10
                 : (a >= lo + 1 ? 2'b01 : 2'b00);
        return a < lo ? 2'b00
             : (a <= hi - 1 ? 2'b01 : 2'b10);
    endfunction

    function automatic int wsum(int q [$]);
        int s = 0;
        foreach (q[i]) s += q[i];
        return s;
    endfunction

    task automatic model_reset();
        win.delete();
        hwin.delete();
        m_primed = 0;
        m_tl = 2'b01;
        m_hl = 2'b01;
        m_tavg = 0;
        m_havg = 0;
        m_rej = 0;
    endtask

    task automatic model_accept(input int t, input int h);
        if (!m_primed) begin
            win = '{t, t, t, t};
            hwin = '{h, h, h, h};
        end else begin
            void'(win.pop_front());
            void'(hwin.pop_front());
            win.push_back(t);
            hwin.push_back(h);
        end
        m_tavg = wsum(win) / 4;
        m_havg = wsum(hwin) / 4;
        m_tl = nxt_lvl(m_tl, !m_primed, m_tavg, 18, 28);
        m_hl = nxt_lvl(m_hl, !m_primed, m_havg, 30, 70);
        m_primed = 1;
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, "_tavg"}, temp_avg, m_tavg);
        chk({tag, "_havg"}, hum_avg, m_havg);
        chk({tag, "_tlvl"}, temp_level, m_tl);
        chk({tag, "_hlvl"}, hum_level, m_hl);
        chk({tag, "_rej"}, reject_cnt, m_rej);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        chk_outs("rst");
        chk("rst_stale", stale, 1);
        chk("rst_upd", update, 0);
    endtask

    task automatic send(input int t, input int h,
                        input bit hold);
        bit acc;
        int upd_at;
        int nupd;
        int len;
        acc = (t <= 50) && (h <= 95);
        upd_at = -1;
        nupd = 0;
        len = hold ? 20 : 6;
        temperature = {8'(t), 8'($urandom_range(0, 255))};
        humidity = {8'(h), 8'($urandom_range(0, 255))};
        valid = 1'b1;
        for (int i = 1; i <= len; i++) begin
            tick();
            if (!hold && i == 1) valid = 1'b0;
            if (update) begin
                nupd++;
                if (upd_at < 0) upd_at = i;
            end
            if (acc && i == 3) begin
                model_accept(t, h);
                chk_outs("acc");
                chk("acc_stale", stale, 0);
            end
        end
        if (!acc) begin
            if (m_rej < 255) m_rej++;
            chk_outs("rej");
        end
        chk("upd_lat", upd_at, acc ? 3 : -1);
        chk("upd_cnt", nupd, acc ? 1 : 0);
        if (hold) begin
            valid = 1'b0;
            tick();
        end
    endtask

    initial begin
        int seq2 [7] = '{20, 20, 20, 40, 40, 40, 40};
        int exp2 [7] = '{20, 20, 20, 25, 30, 35, 40};
        int t;
        int h;
        int nu;

        do_reset();

        send(25, 50, 0);
        chk("t1_tavg", temp_avg, 25);
        chk("t1_havg", hum_avg, 50);
        chk("t1_lvl", {temp_level, hum_level}, 4'b0101);

        do_reset();
        send(20, 50, 0);
        for (int i = 0; i < 7; i++) begin
            send(seq2[i], 50, 0);
            chk("t2_avg", temp_avg, exp2[i]);
        end

        do_reset();
        send(29, 50, 0);
        chk("t3a", temp_level, 2'b10);
        send(25, 50, 0);
        chk("t3b_avg", temp_avg, 28);
        chk("t3b", temp_level, 2'b10);
        send(25, 50, 0);
        chk("t3c_avg", temp_avg, 27);
        chk("t3c", temp_level, 2'b01);

        send(60, 50, 0);
        chk("t4_rej", reject_cnt, 1);
        chk("t4_avg", temp_avg, 27);

        for (int i = 0; i < 80; i++) begin
            t = $urandom_range(10, 56);
            h = $urandom_range(20, 99);
            send(t, h, 0);
            repeat ($urandom_range(0, 3)) tick();
        end

        send(25, 50, 0);
        repeat (96) tick();
        chk("stale_99", stale, 0);
        tick();
        chk("stale_100", stale, 1);
        repeat (20) tick();
        chk("stale_sat", stale, 1);
        send(22, 40, 0);
        chk("stale_clr", stale, 0);

        send(24, 45, 1);

        for (int i = 0; i < 260; i++)
            send(60, 99, 0);
        chk("rej_sat", reject_cnt, 255);

        temperature = {8'd26, 8'd0};
        humidity = {8'd55, 8'd0};
        valid = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        valid = 1'b0;
        tick();
        rst = 1'b0;
        model_reset();
        chk_outs("midrst");
        chk("midrst_stale", stale, 1);
        chk("midrst_upd", update, 0);
        nu = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (update) nu++;
        end
        chk("midrst_noupd", nu, 0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
